// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: alu_op classes, funct codes,
// 4-bit control codes and the FSM state type.
package alu_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ILL   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_MUL = 4'b1000;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_ERR = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decoder: alu_op/funct -> 4-bit control code and
// an illegal flag. Multiply decodes as illegal when MUL_EN is 0.
module alu_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl_o    = CTRL_ERR;
    illegal_o = 1'b1;
    case (alu_op_i)
      ALU_OP_ADD: begin
        ctrl_o    = CTRL_ADD;
        illegal_o = 1'b0;
      end
      ALU_OP_SUB: begin
        ctrl_o    = CTRL_SUB;
        illegal_o = 1'b0;
      end
      ALU_OP_RTYPE: begin
        illegal_o = 1'b0;
        case (funct_i)
          FUNCT_ADD: ctrl_o = CTRL_ADD;
          FUNCT_SUB: ctrl_o = CTRL_SUB;
          FUNCT_AND: ctrl_o = CTRL_AND;
          FUNCT_OR:  ctrl_o = CTRL_OR;
          FUNCT_NOR: ctrl_o = CTRL_NOR;
          FUNCT_SLT: ctrl_o = CTRL_SLT;
          FUNCT_MUL: begin
            if (MUL_EN) ctrl_o = CTRL_MUL;
            else        illegal_o = 1'b1;
          end
          default:   illegal_o = 1'b1;
        endcase
      end
      ALU_OP_ILL: begin
        ctrl_o    = CTRL_ERR;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle logic/arithmetic ops plus an
// iterative shift-add multiply, with registered result, control code and flags.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_ctrl,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   mcand_q,     mcand_d;
  logic [WIDTH-1:0]   mplier_q,    mplier_d;
  logic [WIDTH-1:0]   acc_q,       acc_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   res_q,       res_d;
  logic [3:0]         ctrl_q,      ctrl_d;
  logic               zero_q,      zero_d;
  logic               ovf_q,       ovf_d;
  logic               err_q,       err_d;

  logic [3:0]         dec_ctrl;
  logic               dec_illegal;
  logic [WIDTH-1:0]   sum, diff, alu_res, acc_next;
  logic               alu_ovf;

  alu_decode #(.MUL_EN(MUL_EN)) u_decode (
    .alu_op_i (alu_op),
    .funct_i  (funct),
    .ctrl_o   (dec_ctrl),
    .illegal_o(dec_illegal)
  );

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // Single-cycle datapath; illegal and multiply codes yield zero here.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (dec_ctrl)
      CTRL_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      CTRL_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      CTRL_AND: alu_res = op_a & op_b;
      CTRL_OR:  alu_res = op_a | op_b;
      CTRL_NOR: alu_res = ~(op_a | op_b);
      CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default:  alu_res = '0;
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    ctrl_d      = ctrl_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready) begin
          if (dec_ctrl == CTRL_MUL) begin
            mcand_d     = op_a;
            mplier_d    = op_b;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = MUL;
          end else begin
            out_valid_d = 1'b1;
            res_d       = alu_res;
            ctrl_d      = dec_ctrl;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            err_d       = dec_illegal;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          out_valid_d = 1'b1;
          res_d       = acc_next;
          ctrl_d      = CTRL_MUL;
          zero_d      = (acc_next == '0);
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          cnt_d       = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ctrl_q      <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      ctrl_q      <= ctrl_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_ctrl   = ctrl_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus a randomized
// handshake run scored against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   ctrl;
    logic         zero;
    logic         ovf;
    logic         err;
  } exp_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_SLT, K_MUL, K_ILL} kind_e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_valid2 = 1'b0;
  logic         out_ready = 1'b1, out_ready2 = 1'b1;
  logic [1:0]   alu_op = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] op_a = '0, op_b = '0;

  logic         in_ready, out_valid, out_zero, out_ovf, out_err;
  logic [W-1:0] out_result;
  logic [3:0]   out_ctrl;
  logic         in_ready2, out_valid2, out_zero2, out_ovf2, out_err2;
  logic [W-1:0] out_result2;
  logic [3:0]   out_ctrl2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ctrl(out_ctrl), .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err)
  );

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_result(out_result2),
    .out_ctrl(out_ctrl2), .out_zero(out_zero2), .out_ovf(out_ovf2), .out_err(out_err2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit mul_en);
    exp_t        e;
    kind_e       k;
    longint      sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    k  = K_ILL;
    if (op == 2'b00)      k = K_ADD;
    else if (op == 2'b01) k = K_SUB;
    else if (op == 2'b10) begin
      case (f)
        6'b100000: k = K_ADD;
        6'b100010: k = K_SUB;
        6'b100100: k = K_AND;
        6'b100101: k = K_OR;
        6'b100111: k = K_NOR;
        6'b101010: k = K_SLT;
        6'b011000: k = mul_en ? K_MUL : K_ILL;
        default:   k = K_ILL;
      endcase
    end
    e = '0;
    r = 0;
    case (k)
      K_ADD: begin r = sa + sb; e.res = r[31:0]; e.ctrl = 4'b0010; end
      K_SUB: begin r = sa - sb; e.res = r[31:0]; e.ctrl = 4'b0110; end
      K_AND: begin e.res = a & b;    e.ctrl = 4'b0000; end
      K_OR:  begin e.res = a | b;    e.ctrl = 4'b0001; end
      K_NOR: begin e.res = ~(a | b); e.ctrl = 4'b1100; end
      K_SLT: begin e.res = (sa < sb) ? 32'd1 : 32'd0; e.ctrl = 4'b0111; end
      K_MUL: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; e.ctrl = 4'b1000; end
      default: begin e.res = '0; e.ctrl = 4'b1111; e.err = 1'b1; end
    endcase
    if (k == K_ADD || k == K_SUB)
      e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    check({tag, "_res"}, 64'(out_result), 64'(e.res));
    check({tag, "_flags"}, 64'({out_ctrl, out_zero, out_ovf, out_err}),
          64'({e.ctrl, e.zero, e.ovf, e.err}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for acceptance, then count cycles until out_valid.
  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit saw_ready);
    int w;
    alu_op = op; funct = f; op_a = a; op_b = b;
    in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    if (w >= 100) check("accept_timeout", 64'(w), 64'(0));
    tick();
    in_valid = 1'b0;
    lat = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
      lat++;
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [5:0] rnd_funct();
    logic [5:0] tbl [8];
    tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100111, 6'b101010, 6'b011000, 6'b111111};
    if ($urandom_range(0, 9) == 0) return 6'($urandom());
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    bit   saw;
    bit   seen_valid;
    exp_t e, hold;
    exp_t q[$];
    int   d;

    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_outs", 64'({out_result, out_ctrl, out_zero, out_ovf, out_err}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    issue(2'b00, 6'b111111, 32'd5, 32'd7, lat, saw);
    check("add_latency", 64'(lat), 64'(0));
    check("add_valid", 64'(out_valid), 64'(1));
    cmp_out("add_5_7", model(2'b00, 6'b111111, 32'd5, 32'd7, 1'b1));

    issue(2'b10, 6'b100010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, lat, saw);
    cmp_out("sub_ovf", model(2'b10, 6'b100010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1));
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, lat, saw);
    cmp_out("slt_neg", model(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b1));
    issue(2'b10, 6'b100111, 32'd0, 32'd0, lat, saw);
    cmp_out("nor_zero", model(2'b10, 6'b100111, 32'd0, 32'd0, 1'b1));
    issue(2'b11, 6'b100000, 32'd3, 32'd4, lat, saw);
    cmp_out("ill_op", model(2'b11, 6'b100000, 32'd3, 32'd4, 1'b1));
    issue(2'b10, 6'b111111, 32'd3, 32'd4, lat, saw);
    check("ill_funct_latency", 64'(lat), 64'(0));
    cmp_out("ill_funct", model(2'b10, 6'b111111, 32'd3, 32'd4, 1'b1));
    issue(2'b01, 6'b100100, 32'd9, 32'd9, lat, saw);
    cmp_out("sub_zero", model(2'b01, 6'b100100, 32'd9, 32'd9, 1'b1));

    issue(2'b10, 6'b011000, 32'd1234, 32'd5678, lat, saw);
    check("mul_latency", 64'(lat), 64'(W));
    check("mul_in_ready_low", 64'(saw), 64'(0));
    check("mul_result_const", 64'(out_result), 64'(7006652));
    cmp_out("mul", model(2'b10, 6'b011000, 32'd1234, 32'd5678, 1'b1));
    // Next request must wait until the edge after the consume edge.
    alu_op = 2'b00; op_a = 32'd100; op_b = 32'd23; in_valid = 1'b1;
    #1;
    check("hold_in_ready", 64'(in_ready), 64'(0));
    tick();
    check("post_mul_consume", 64'(out_valid), 64'(0));
    check("post_mul_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check("post_mul_add_valid", 64'(out_valid), 64'(1));
    cmp_out("post_mul_add", model(2'b00, 6'b000000, 32'd100, 32'd23, 1'b1));
    tick();

    alu_op = 2'b10; funct = 6'b011000; op_a = 32'd1234; op_b = 32'd5678;
    in_valid2 = 1'b1;
    #1;
    check("nomul_ready", 64'(in_ready2), 64'(1));
    tick();
    in_valid2 = 1'b0;
    e = model(2'b10, 6'b011000, 32'd1234, 32'd5678, 1'b0);
    check("nomul_valid", 64'(out_valid2), 64'(1));
    check("nomul_res", 64'(out_result2), 64'(e.res));
    check("nomul_flags", 64'({out_ctrl2, out_zero2, out_ovf2, out_err2}),
          64'({e.ctrl, e.zero, e.ovf, e.err}));

    out_ready = 1'b0;
    issue(2'b10, 6'b100101, 32'h00F0_0F00, 32'h0000_00FF, lat, saw);
    hold = model(2'b10, 6'b100101, 32'h00F0_0F00, 32'h0000_00FF, 1'b1);
    alu_op = 2'b10; funct = 6'b100100; op_a = 32'hDEAD_BEEF; op_b = 32'h0FF0_FFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_valid", 64'(out_valid), 64'(1));
      cmp_out("bp_stable", hold);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check("bp_new_valid", 64'(out_valid), 64'(1));
    cmp_out("bp_new", model(2'b10, 6'b100100, 32'hDEAD_BEEF, 32'h0FF0_FFFF, 1'b1));
    tick();

    alu_op = 2'b10; funct = 6'b011000; op_a = 32'd77; op_b = 32'd99;
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_outs", 64'({out_result, out_ctrl, out_zero, out_ovf, out_err}), 64'(0));
    tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_result", 64'(seen_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    issue(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd2, lat, saw);
    check("midrst_add_latency", 64'(lat), 64'(0));
    cmp_out("midrst_add", model(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd2, 1'b1));
    tick();

    for (int it = 0; it < 400; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1);
      d = $urandom_range(0, 9);
      alu_op = (d < 2) ? 2'b00 : (d < 4) ? 2'b01 : (d == 4) ? 2'b11 : 2'b10;
      funct  = rnd_funct();
      op_a   = rnd_opnd();
      op_b   = rnd_opnd();
      #1;
      if (out_valid) begin
        check("rnd_spurious", 64'(q.size() == 0), 64'(0));
        if (q.size() != 0) begin
          cmp_out("rnd", q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(alu_op, funct, op_a, op_b, 1'b1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      #1;
      if (out_valid) begin
        cmp_out("rnd_drain", q[0]);
        void'(q.pop_front());
      end
      tick();
    end
    check("rnd_drain_empty", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
